// File: rtl/rf_dump_scanner.sv
// Streams all 32 registers of the CPU register file, one 8-word window at a time, over valid/ready.
// Define RF_DUMP_CHECKSUM_EN to append a modulo-2^DATA_WIDTH checksum beat after register 31.
module rf_dump_scanner #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_ra2,
    input  logic [DATA_WIDTH-1:0] i_win0,
    input  logic [DATA_WIDTH-1:0] i_win1,
    input  logic [DATA_WIDTH-1:0] i_win2,
    input  logic [DATA_WIDTH-1:0] i_win3,
    input  logic [DATA_WIDTH-1:0] i_win4,
    input  logic [DATA_WIDTH-1:0] i_win5,
    input  logic [DATA_WIDTH-1:0] i_win6,
    input  logic [DATA_WIDTH-1:0] i_win7,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [ADDR_WIDTH-1:0] o_out_addr,
    output logic                  o_out_last,
    output logic [DATA_WIDTH-1:0] o_out_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_BASE = ADDR_WIDTH'(2**ADDR_WIDTH - 8);
    localparam logic [ADDR_WIDTH-1:0] WIN_STEP  = ADDR_WIDTH'(8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
`ifdef RF_DUMP_CHECKSUM_EN
        S_SUM,
`endif
        S_DONE
    } state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [2:0]            r_idx;
    logic [DATA_WIDTH-1:0] r_buf [8];
    logic [DATA_WIDTH-1:0] w_win [8];
    logic                  w_accept;
    logic                  w_win_end;
    logic                  w_dump_end;
`ifdef RF_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_acc;
`endif

    assign w_win[0] = i_win0;
    assign w_win[1] = i_win1;
    assign w_win[2] = i_win2;
    assign w_win[3] = i_win3;
    assign w_win[4] = i_win4;
    assign w_win[5] = i_win5;
    assign w_win[6] = i_win6;
    assign w_win[7] = i_win7;

    assign w_accept   = o_out_valid && i_out_ready;
    assign w_win_end  = (r_idx == 3'd7);
    assign w_dump_end = w_win_end && (r_base == LAST_BASE);
    // The window base is the registered read address; it reads 0 whenever idle.
    assign o_ra2      = r_base;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_idx   <= '0;
            for (int k = 0; k < 8; k++) r_buf[k] <= '0;
`ifdef RF_DUMP_CHECKSUM_EN
            r_acc   <= '0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_base <= '0;
`ifdef RF_DUMP_CHECKSUM_EN
                    if (i_start) r_acc <= '0;
`endif
                end
                S_LOAD: begin
                    for (int k = 0; k < 8; k++) r_buf[k] <= w_win[k];
                    r_idx <= '0;
                end
                S_SEND: begin
                    if (w_accept) begin
`ifdef RF_DUMP_CHECKSUM_EN
                        r_acc <= r_acc + o_out_data;
`endif
                        if (!w_win_end)
                            r_idx <= r_idx + 3'd1;
                        else if (r_base != LAST_BASE)
                            r_base <= r_base + WIN_STEP;
                    end
                end
                S_DONE: r_base <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_out_valid = 1'b0;
        o_out_addr  = '0;
        o_out_last  = 1'b0;
        o_out_data  = '0;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_LOAD;
            S_LOAD: begin
                o_busy = 1'b1;
                w_next = S_SEND;
            end
            S_SEND: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                o_out_data  = r_buf[r_idx];
                o_out_addr  = r_base + ADDR_WIDTH'(r_idx);
`ifdef RF_DUMP_CHECKSUM_EN
                if (w_accept && w_dump_end) w_next = S_SUM;
`else
                o_out_last  = w_dump_end;
                if (w_accept && w_dump_end) w_next = S_DONE;
`endif
                else if (w_accept && w_win_end) w_next = S_LOAD;
            end
`ifdef RF_DUMP_CHECKSUM_EN
            S_SUM: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                o_out_data  = r_acc;
                o_out_last  = 1'b1;
                if (w_accept) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rf_dump_scanner.sv
// Self-checking bench for rf_dump_scanner: register-file model, randomized backpressure, stream scoreboard.
module tb_rf_dump_scanner;

`ifdef RF_DUMP_CHECKSUM_EN
    localparam int NB = 33;
    localparam int DONE_CYC = 38;
`else
    localparam int NB = 32;
    localparam int DONE_CYC = 37;
`endif

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_out_ready;
    logic        o_busy, o_done, o_out_valid, o_out_last;
    logic [4:0]  o_ra2, o_out_addr;
    logic [31:0] o_out_data;
    logic [31:0] rf  [32];
    logic [31:0] win [8];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 8; k++) win[k] = rf[5'(o_ra2 + 5'(k))];
    end

    rf_dump_scanner #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_ra2(o_ra2),
        .i_win0(win[0]), .i_win1(win[1]), .i_win2(win[2]), .i_win3(win[3]),
        .i_win4(win[4]), .i_win5(win[5]), .i_win6(win[6]), .i_win7(win[7]),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_addr(o_out_addr),
        .o_out_last(o_out_last), .o_out_data(o_out_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".busy"},  64'(o_busy), 64'd0);
        chk({tag, ".done"},  64'(o_done), 64'd0);
        chk({tag, ".valid"}, 64'(o_out_valid), 64'd0);
        chk({tag, ".last"},  64'(o_out_last), 64'd0);
        chk({tag, ".addr"},  64'(o_out_addr), 64'd0);
        chk({tag, ".data"},  64'(o_out_data), 64'd0);
        chk({tag, ".ra2"},   64'(o_ra2), 64'd0);
    endtask

    task automatic fill_rf(input bit ramp);
        for (int k = 0; k < 32; k++) rf[k] = ramp ? 32'(k * 3) : $urandom;
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic run_dump(input int mode, input bit do_wr, input bit extra_start);
        logic [31:0] exd [32];
        logic [31:0] sum;
        logic [31:0] sv_d;
        logic [4:0]  sv_a;
        logic        sv_l, stalled, rdy, wrote20, wrote3;
        int          cyc, beat, dones, done_cyc, first_vld;
        logic [1:0]  pat [4];
        pat[0] = 2'd1; pat[1] = 2'd0; pat[2] = 2'd0; pat[3] = 2'd1;
        for (int k = 0; k < 32; k++) exd[k] = rf[k];
        stalled = 0; wrote20 = 0; wrote3 = 0;
        beat = 0; dones = 0; done_cyc = -1; first_vld = -1; cyc = 0;
        sv_d = '0; sv_a = '0; sv_l = 0;
        @(posedge clk); #1 i_start = 1'b1;
        @(negedge clk);
        chk("start.idle_busy", 64'(o_busy), 64'd0);
        @(posedge clk); #1 i_start = 1'b0;
        while (dones == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (mode == 0 && cyc <= 28 && (cyc - 1) % 9 == 0) begin
                chk("load.ra2", 64'(o_ra2), 64'((cyc - 1) / 9 * 8));
                chk("load.busy", 64'(o_busy), 64'd1);
                chk("load.valid", 64'(o_out_valid), 64'd0);
            end
            if (stalled) begin
                chk("stall.valid", 64'(o_out_valid), 64'd1);
                chk("stall.data", 64'(o_out_data), 64'(sv_d));
                chk("stall.addr", 64'(o_out_addr), 64'(sv_a));
                chk("stall.last", 64'(o_out_last), 64'(sv_l));
            end
            i_start = (extra_start && (cyc % 5 == 0 || o_done)) ? 1'b1 : 1'b0;
            if (o_done) begin
                dones++;
                done_cyc = cyc;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = pat[cyc % 4][0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_out_ready = rdy;
            if (o_out_valid) begin
                if (first_vld < 0) first_vld = cyc;
                if (beat < 32) begin
                    chk("beat.addr", 64'(o_out_addr), 64'(beat));
                    chk("beat.data", 64'(o_out_data), 64'(exd[beat]));
                    chk("beat.last", 64'(o_out_last), 64'((NB == 32) && (beat == 31)));
                end else if (beat < NB) begin
                    sum = '0;
                    for (int k = 0; k < 32; k++) sum += exd[k];
                    chk("sum.data", 64'(o_out_data), 64'(sum));
                    chk("sum.addr", 64'(o_out_addr), 64'd0);
                    chk("sum.last", 64'(o_out_last), 64'd1);
                end else begin
                    chk("extra_beat", 64'(beat), 64'(NB - 1));
                end
                stalled = !rdy;
                sv_d = o_out_data; sv_a = o_out_addr; sv_l = o_out_last;
                if (rdy) beat++;
            end else begin
                stalled = 0;
            end
            // Writes while window 0 is streaming: only not-yet-loaded windows pick them up.
            if (do_wr && beat >= 2 && beat <= 6) begin
                if (!wrote20) begin
                    rf[20] = 32'hDEAD; wrote20 = 1;
                    if (20 >= 8 * (beat / 8 + 1)) exd[20] = 32'hDEAD;
                end else if (!wrote3) begin
                    rf[3] = ~rf[3]; wrote3 = 1;
                    if (3 >= 8 * (beat / 8 + 1)) exd[3] = rf[3];
                end
            end
        end
        i_start = 1'b0;
        chk("dump.done_seen", 64'(dones), 64'd1);
        chk("dump.beats", 64'(beat), 64'(NB));
        if (mode == 0) begin
            chk("dump.first_valid_cyc", 64'(first_vld), 64'd2);
            chk("dump.done_cyc", 64'(done_cyc), 64'(DONE_CYC));
        end
        if (do_wr) chk("dump.wr_addr20", 64'(exd[20]), 64'h0000DEAD);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post.busy", 64'(o_busy), 64'd0);
            chk("post.done", 64'(o_done), 64'd0);
        end
    endtask

    task automatic reset_mid_dump();
        int beat, cyc;
        beat = 0; cyc = 0;
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        i_out_ready = 1'b1;
        while (beat < 12 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (o_out_valid) beat++;
        end
        chk("rst.reach_beat12", 64'(beat), 64'd12);
        i_rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst.mid");
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst.no_done", 64'(o_done), 64'd0);
            chk("rst.no_busy", 64'(o_busy), 64'd0);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_out_ready = 1'b0;
        fill_rf(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        i_rst = 1'b0;

        run_dump(0, 1'b0, 1'b0);
        run_dump(1, 1'b0, 1'b0);
        fill_rf(1'b0);
        run_dump(2, 1'b1, 1'b0);
        fill_rf(1'b0);
        run_dump(2, 1'b0, 1'b1);
        fill_rf(1'b0);
        reset_mid_dump();
        run_dump(2, 1'b0, 1'b0);
        fill_rf(1'b0);
        run_dump(0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_dump_scanner.md
# rf_dump_scanner

Register-file dump engine sitting directly downstream of the CPU register file's debug window port. It drives the window base address (`ra2`), captures the 8 consecutive registers the register file returns, and streams all 32 registers out one word per beat over a valid/ready interface. The consumer is a UART or display sink. An optional checksum word can follow the register words.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register word width
- `ADDR_WIDTH`, 5, register address width; the file holds 2^ADDR_WIDTH = 32 registers, and the window is fixed at 8

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin dump; sampled only in IDLE
- `busy`  out  1  high in LOAD, SEND and SUM
- `done`  out  1  one-cycle pulse when the dump is complete
- `ra2`  out  ADDR_WIDTH  window base address to the register file (registered)
- `win0`..`win7`  in  DATA_WIDTH each  register file window words, `register[ra2+k]`, combinational from the file
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  sink accepts the word
- `out_addr`  out  ADDR_WIDTH  register index of `out_data`
- `out_last`  out  1  marks the final beat of the dump
- `out_data`  out  DATA_WIDTH  streamed word

## Operation
- FSM states: IDLE, LOAD, SEND, SUM (present only with the macro), DONE.
- **IDLE:** `base`=0, `ra2`=0. If `start`=1, go to LOAD.
- **LOAD:** `ra2`=`base`. At the clock edge, capture `win0`..`win7` into an 8-entry buffer, set `idx`=0, go to SEND.
- **SEND:**
  - Outputs: `out_valid`=1, `out_data`=`buf[idx]`, `out_addr`=`base+idx`.
  - A beat is accepted when `out_valid` and `out_ready` are both high.
  - On acceptance with `idx`<7: `idx`++.
  - On acceptance with `idx`=7 and `base`<24: `base`+=8, go to LOAD.
  - On acceptance with `idx`=7 and `base`=24: go to SUM if enabled, else DONE.
- **SUM:** `out_valid`=1, `out_data`=checksum, `out_addr`=0, `out_last`=1. On acceptance, go to DONE.
- **DONE:** `done`=1 for one cycle, then return to IDLE.
- **`out_last`:** high on the beat for register 31 when the checksum is disabled; high only on the SUM beat when it is enabled.
- **Checksum:** unsigned sum of all 32 streamed words modulo 2^DATA_WIDTH. The accumulator clears on the IDLE→LOAD transition and adds `out_data` on each accepted register beat.
- **Consistency:** snapshot consistency is per window only.
  - A write landing on the same edge as a LOAD capture is not seen; the pre-write value is captured.
  - Writes to windows not yet loaded are seen.
- **Register 0:** has no hardwired-zero handling; it is dumped as stored.
- **Address range:** `base` takes only the values 0, 8, 16 and 24, so `ra2+7` never wraps.

## Timing
- **Reset values:** `busy`=0, `done`=0, `ra2`=0, `out_valid`=0, `out_last`=0, `out_addr`=0, `out_data`=0, state=IDLE, accumulator=0.
- **Reset mid-dump:** on the next edge, force IDLE and the reset values. A beat in flight is dropped and no `done` is produced.
- **Start latency:** `start` high at cycle 0 in IDLE gives LOAD at cycle 1 and the first `out_valid` at cycle 2.
- **Zero-stall throughput (`out_ready` held at 1):**
  - Each window costs 1 LOAD cycle plus 8 SEND cycles.
  - Register 31 is presented at cycle 36.
  - Without the macro, `done` pulses at cycle 37.
  - With the macro, the checksum is presented at cycle 37 and `done` pulses at cycle 38.
- **Backpressure:** while `out_valid`=1 and `out_ready`=0, `out_data`, `out_addr` and `out_last` hold stable. `out_valid` never drops before acceptance.
- **Ignored `start`:** `start` is ignored outside IDLE, including during DONE.

## Configuration
- **`RF_DUMP_CHECKSUM_EN` defined:** the SUM state and accumulator exist. A 33rd beat carries the checksum, and `out_last` marks that beat.
- **`RF_DUMP_CHECKSUM_EN` undefined:** no SUM state and no accumulator. The stream is exactly 32 beats, and `out_last` marks register 31.

## Test plan
- Load `register[k]`=`k*3`, pulse `start`, hold `out_ready`=1. Expect 32 beats with `out_addr`=0..31 and `out_data`=0,3,…,93. Expect `ra2` to take 0,8,16,24 in LOAD cycles. Expect `done` at cycle 37 (macro off).
- Macro on, same data. Expect a 33rd beat with `out_data`=1488, `out_last`=1, and `done` at cycle 38.
- Toggle `out_ready` 1,0,0,1 repeatedly. Expect `out_data` and `out_addr` to stay stable across stalls, the same 32-word sequence, and no duplicated or skipped addresses.
- During SEND of window 0, write `register[20]`=0xDEAD. Expect beat 20 to read 0xDEAD. A write to `register[3]` in the same phase does not alter the streamed word 3.
- Assert `rst` at beat 12. On the next edge expect `out_valid`=0, `ra2`=0 and `busy`=0, with no `done`. A new `start` then restarts the dump from address 0.
- Pulse `start` while `busy`=1. Expect no effect: exactly one dump and one `done` pulse.
